mig_ui_model: RTL and testbench
===============================

# mig_ui_model

Behavioural, synthesizable model of the Xilinx MIG user interface that sits directly downstream of `traffic_merger` in simulation benches. It consumes the `app_*` command/write stream and produces the read-data stream and handshakes, backed by an internal 128-bit line memory. It lets `memorytb_top`-style benches run the processor without the real DDR controller, with configurable calibration delay, read latency and `app_rdy` back-pressure.

## Interface
- `DEPTH`, 4096: number of 128-bit lines; power of two.
- `READ_LATENCY`, 8: cycles from read-command acceptance to `app_rd_data_valid`; at least 1.
- `CALIB_CYCLES`, 64: cycles after reset release before `init_calib_complete` rises.
- `STALL_PERIOD`, 0: when nonzero, `app_rdy` is forced low one cycle in every `STALL_PERIOD`; 0 disables stalling.
- `clk_in` in 1: single clock (ui_clk domain).
- `rst_in` in 1: synchronous, active-low reset.
- `app_addr` in 27: byte-beat address; line index = `app_addr[3 +: $clog2(DEPTH)]`, upper bits ignored (aliasing).
- `app_cmd` in 3: 3'b000 write, 3'b001 read; other values accepted and discarded.
- `app_en` in 1: command valid.
- `app_rdy` out 1: command accepted when `app_en && app_rdy`.
- `app_wdf_data` in 128: write data.
- `app_wdf_mask` in 16: per-byte mask, 1 = byte NOT written.
- `app_wdf_wren` in 1: write-data valid.
- `app_wdf_end` in 1: last beat; always 1 for single-beat bursts, ignored.
- `app_wdf_rdy` out 1: write data accepted when `app_wdf_wren && app_wdf_rdy`.
- `app_rd_data` out 128: read data.
- `app_rd_data_valid` out 1: read data valid; no back-pressure.
- `app_rd_data_end` out 1: equals `app_rd_data_valid`.
- `app_sr_req`, `app_ref_req`, `app_zq_req` in 1 each: maintenance requests.
- `app_sr_active` out 1: constant 0.
- `app_ref_ack`, `app_zq_ack` out 1 each: one-cycle ack one cycle after the corresponding request is sampled high.
- `init_calib_complete` out 1: calibration done.

## Operation
- States: CALIB (counting) -> RUN. Reset enters CALIB with counter 0; RUN entered when counter reaches `CALIB_CYCLES-1`; `init_calib_complete` registered high from then on.
- In CALIB: `app_rdy`=0, `app_wdf_rdy`=0; requests ignored except ref/zq acks.
- Write-data FIFO (4 entries, data+mask). `app_wdf_rdy` = RUN && FIFO not full. Data may precede its command by up to 4 beats.
- Pending-write register (one line index). Write command accepted only if no write pending.
- Commit: when a write is pending (or accepted this cycle) and FIFO is non-empty (or data pushed this cycle, bypass), pop one entry and merge unmasked bytes into the memory line; pending clears.
- `app_rdy` = RUN && no pending write && not stall cycle. Reads therefore never overtake a write whose data has not arrived.
- Read: at acceptance the addressed line is sampled (after any same-cycle commit) into a `READ_LATENCY`-deep valid/data shift pipeline; responses leave strictly in order, one per cycle max.
- Stall counter free-runs in RUN, wraps at `STALL_PERIOD-1`; stall cycle when counter == `STALL_PERIOD-1`.
- Memory is not reset; initialised to zero at time 0.

## Timing
- Reset values: `app_rdy` 0, `app_wdf_rdy` 0, `app_rd_data` 0, `app_rd_data_valid` 0, `app_rd_data_end` 0, acks 0, `init_calib_complete` 0, `app_sr_active` 0.
- Read accepted at cycle t -> `app_rd_data_valid` high at t+`READ_LATENCY` for exactly one cycle.
- Write command and data in same cycle with empty FIFO -> memory updated at end of that cycle; read accepted next cycle returns new data.
- Simultaneous FIFO push and pop: occupancy unchanged; full FIFO never pops-and-pushes beyond 4.
- Reset mid-operation: read pipeline, FIFO, pending write and stall counter cleared; in-flight reads lost; calibration restarts.

## Structure
- Shared package `mig_pkg`: `MIG_CMD_WRITE`=3'b000, `MIG_CMD_READ`=3'b001, `MIG_DATA_BITS`=128, `MIG_MASK_BITS`=16.
- Sub-module `wdf_fifo`: 4-entry synchronous FIFO of {mask, data} with full/empty, same reset.

## Test plan
- Reset release -> `init_calib_complete` rises exactly 64 cycles later; `app_rdy`/`app_wdf_rdy` 0 until then.
- Write 0xDEADBEEF... to addr 0x10 (mask 0), then read addr 0x10 -> matching data after 8 cycles, `app_rd_data_end` high with valid.
- Write mask 16'hFFF0 over line of all-ones with zeros -> only low 4 bytes zeroed on readback.
- Write command with data delayed 5 cycles, then read same addr -> `app_rdy` low until data arrives; read returns new data.
- Four data beats pushed before commands -> `app_wdf_rdy` drops after 4th; back-to-back 8 reads -> 8 in-order responses consecutive cycles; `STALL_PERIOD`=3 -> `app_rdy` low every 3rd RUN cycle.
- `rst_in` low with 3 reads in flight -> no `app_rd_data_valid` afterward; calibration repeats.

Source files
------------

// File: rtl/mig_pkg.sv
// Shared constants, types and byte-merge helper for the MIG user-interface model.
package mig_pkg;

  localparam logic [2:0] MIG_CMD_WRITE = 3'b000;
  localparam logic [2:0] MIG_CMD_READ  = 3'b001;
  localparam int MIG_DATA_BITS = 128;
  localparam int MIG_MASK_BITS = 16;

  typedef enum logic {
    MIG_CALIB = 1'b0,
    MIG_RUN   = 1'b1
  } mig_state_t;

  typedef struct packed {
    logic [MIG_MASK_BITS-1:0] mask;
    logic [MIG_DATA_BITS-1:0] data;
  } wdf_beat_t;

  // Mask bit set means the byte keeps its old value.
  function automatic logic [MIG_DATA_BITS-1:0] merge_bytes(
    input logic [MIG_DATA_BITS-1:0] old_line,
    input wdf_beat_t beat
  );
    logic [MIG_DATA_BITS-1:0] line;
    line = old_line;
    for (int b = 0; b < MIG_MASK_BITS; b++) begin
      if (!beat.mask[b]) line[b*8 +: 8] = beat.data[b*8 +: 8];
    end
    return line;
  endfunction

endpackage

// File: rtl/wdf_fifo.sv
// Four-entry write-data FIFO holding {mask, data} beats until their command arrives.
module wdf_fifo
  import mig_pkg::*;
(
  input  logic      clk_in,
  input  logic      rst_in,
  input  logic      push,
  input  logic      pop,
  input  wdf_beat_t din,
  output wdf_beat_t dout,
  output logic      full,
  output logic      empty
);

  wdf_beat_t  entries [4];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic [2:0] count;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop && (count != 3'd0);
  assign do_push = push && (count != 3'd4);
  assign full    = (count == 3'd4);
  assign empty   = (count == 3'd0);
  assign dout    = entries[rd_ptr];

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 3'd0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 2'd1;
      if (do_pop)  rd_ptr <= rd_ptr + 2'd1;
      count <= count + {2'b00, do_push} - {2'b00, do_pop};
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) entries[wr_ptr] <= din;
  end

endmodule

// File: rtl/mig_ui_model.sv
// Behavioural MIG UI: calibration delay, write-data FIFO with one pending write,
// 128-bit line memory, fixed-latency in-order read pipeline and optional app_rdy stalls.
module mig_ui_model
  import mig_pkg::*;
#(
  parameter int DEPTH        = 4096,
  parameter int READ_LATENCY = 8,
  parameter int CALIB_CYCLES = 64,
  parameter int STALL_PERIOD = 0
) (
  input  logic                     clk_in,
  input  logic                     rst_in,
  input  logic [26:0]              app_addr,
  input  logic [2:0]               app_cmd,
  input  logic                     app_en,
  output logic                     app_rdy,
  input  logic [MIG_DATA_BITS-1:0] app_wdf_data,
  input  logic [MIG_MASK_BITS-1:0] app_wdf_mask,
  input  logic                     app_wdf_wren,
  input  logic                     app_wdf_end,
  output logic                     app_wdf_rdy,
  output logic [MIG_DATA_BITS-1:0] app_rd_data,
  output logic                     app_rd_data_valid,
  output logic                     app_rd_data_end,
  input  logic                     app_sr_req,
  input  logic                     app_ref_req,
  input  logic                     app_zq_req,
  output logic                     app_sr_active,
  output logic                     app_ref_ack,
  output logic                     app_zq_ack,
  output logic                     init_calib_complete
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int CAL_W = (CALIB_CYCLES > 1) ? $clog2(CALIB_CYCLES) : 1;
  localparam int STL_W = (STALL_PERIOD > 1) ? $clog2(STALL_PERIOD) : 1;

  mig_state_t               state;
  logic [CAL_W-1:0]         calib_cnt;
  logic [STL_W-1:0]         stall_cnt;
  logic                     pend_valid;
  logic [IDX_W-1:0]         pend_idx;
  logic [READ_LATENCY-1:0]  rd_v;
  logic [MIG_DATA_BITS-1:0] rd_d [READ_LATENCY];
  logic [MIG_DATA_BITS-1:0] mem [DEPTH];

  logic                     run;
  logic                     stall_cyc;
  logic                     cmd_fire;
  logic                     wr_acc;
  logic                     rd_acc;
  logic                     wdf_push;
  logic                     commit;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [IDX_W-1:0]         cmd_idx;
  logic [IDX_W-1:0]         commit_idx;
  wdf_beat_t                in_beat;
  wdf_beat_t                head_beat;
  wdf_beat_t                commit_beat;
  logic [MIG_DATA_BITS-1:0] merged_line;
  logic [MIG_DATA_BITS-1:0] rd_line;
  logic                     unused_ok;

  // Handshake: a command transfers on app_en && app_rdy, a write beat on
  // app_wdf_wren && app_wdf_rdy; read data has no ready and must be taken when valid.
  assign run         = (state == MIG_RUN);
  assign stall_cyc   = (STALL_PERIOD != 0) && (stall_cnt == STL_W'(STALL_PERIOD - 1));
  assign app_rdy     = run && !pend_valid && !stall_cyc;
  assign app_wdf_rdy = run && !fifo_full;

  assign cmd_fire = app_en && app_rdy;
  assign wr_acc   = cmd_fire && (app_cmd == MIG_CMD_WRITE);
  assign rd_acc   = cmd_fire && (app_cmd == MIG_CMD_READ);
  assign wdf_push = app_wdf_wren && app_wdf_rdy;
  assign cmd_idx  = app_addr[3 +: IDX_W];
  assign in_beat  = {app_wdf_mask, app_wdf_data};

  // With an empty FIFO the incoming beat bypasses straight into the commit.
  assign commit      = (pend_valid || wr_acc) && (!fifo_empty || wdf_push);
  assign commit_beat = fifo_empty ? in_beat : head_beat;
  assign commit_idx  = pend_valid ? pend_idx : cmd_idx;
  assign merged_line = merge_bytes(mem[commit_idx], commit_beat);
  assign rd_line     = (commit && (commit_idx == cmd_idx)) ? merged_line : mem[cmd_idx];

  wdf_fifo u_wdf_fifo (
    .clk_in (clk_in),
    .rst_in (rst_in),
    .push   (wdf_push && !(commit && fifo_empty)),
    .pop    (commit && !fifo_empty),
    .din    (in_beat),
    .dout   (head_beat),
    .full   (fifo_full),
    .empty  (fifo_empty)
  );

  always_ff @(posedge clk_in) begin
    if (commit) mem[commit_idx] <= merged_line;
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state               <= MIG_CALIB;
      calib_cnt           <= '0;
      init_calib_complete <= 1'b0;
      stall_cnt           <= '0;
      pend_valid          <= 1'b0;
      pend_idx            <= '0;
      app_ref_ack         <= 1'b0;
      app_zq_ack          <= 1'b0;
      rd_v                <= '0;
      for (int i = 0; i < READ_LATENCY; i++) rd_d[i] <= '0;
    end else begin
      app_ref_ack <= app_ref_req;
      app_zq_ack  <= app_zq_req;
      case (state)
        MIG_CALIB: begin
          if (calib_cnt == CAL_W'(CALIB_CYCLES - 1)) begin
            state               <= MIG_RUN;
            init_calib_complete <= 1'b1;
          end else begin
            calib_cnt <= calib_cnt + CAL_W'(1);
          end
        end
        MIG_RUN: begin
          if (STALL_PERIOD != 0) stall_cnt <= stall_cyc ? '0 : stall_cnt + STL_W'(1);
        end
      endcase
      if (wr_acc && !commit) begin
        pend_valid <= 1'b1;
        pend_idx   <= cmd_idx;
      end else if (commit) begin
        pend_valid <= 1'b0;
      end
      rd_v[0] <= rd_acc;
      rd_d[0] <= rd_acc ? rd_line : '0;
      for (int i = 1; i < READ_LATENCY; i++) begin
        rd_v[i] <= rd_v[i-1];
        rd_d[i] <= rd_d[i-1];
      end
    end
  end

  assign app_rd_data       = rd_d[READ_LATENCY-1];
  assign app_rd_data_valid = rd_v[READ_LATENCY-1];
  assign app_rd_data_end   = rd_v[READ_LATENCY-1];
  assign app_sr_active     = 1'b0;

  // Self-refresh and burst-end inputs and the aliased address bits carry no behaviour.
  assign unused_ok = ^{app_wdf_end, app_sr_req, app_addr};

endmodule

// File: tb/tb_mig_ui_model.sv
// Bench for mig_ui_model: directed steps plus random traffic scored against a queue-based reference.
module tb_mig_ui_model;
  import mig_pkg::*;

  localparam int L     = 8;
  localparam int CAL   = 64;
  localparam int CAL_S = 4;
  localparam int DEPTH = 4096;

  logic         clk_in = 1'b0;
  logic         rst_in;
  logic [26:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy;
  logic [127:0] app_wdf_data;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic         app_wdf_rdy;
  logic [127:0] app_rd_data;
  logic         app_rd_data_valid;
  logic         app_rd_data_end;
  logic         app_sr_req;
  logic         app_ref_req;
  logic         app_zq_req;
  logic         app_sr_active;
  logic         app_ref_ack;
  logic         app_zq_ack;
  logic         init_calib_complete;

  logic         s_rdy, s_wdf_rdy, s_valid, s_end, s_sr, s_ref_ack, s_zq_ack, s_calib;
  logic [127:0] s_rd_data;

  // Clock / reset
  always #5 clk_in = ~clk_in;

  mig_ui_model #(.DEPTH(DEPTH), .READ_LATENCY(L), .CALIB_CYCLES(CAL), .STALL_PERIOD(0)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en),
    .app_rdy(app_rdy), .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end), .app_sr_req(app_sr_req), .app_ref_req(app_ref_req),
    .app_zq_req(app_zq_req), .app_sr_active(app_sr_active), .app_ref_ack(app_ref_ack),
    .app_zq_ack(app_zq_ack), .init_calib_complete(init_calib_complete)
  );

  mig_ui_model #(.DEPTH(DEPTH), .READ_LATENCY(L), .CALIB_CYCLES(CAL_S), .STALL_PERIOD(3)) dut_s (
    .clk_in(clk_in), .rst_in(rst_in), .app_addr(27'd0), .app_cmd(3'd0), .app_en(1'b0),
    .app_rdy(s_rdy), .app_wdf_data(128'd0), .app_wdf_mask(16'd0),
    .app_wdf_wren(1'b0), .app_wdf_end(1'b0), .app_wdf_rdy(s_wdf_rdy),
    .app_rd_data(s_rd_data), .app_rd_data_valid(s_valid),
    .app_rd_data_end(s_end), .app_sr_req(1'b0), .app_ref_req(1'b0),
    .app_zq_req(1'b0), .app_sr_active(s_sr), .app_ref_ack(s_ref_ack),
    .app_zq_ack(s_zq_ack), .init_calib_complete(s_calib)
  );

  // Reference model and scoreboard
  logic [127:0] mem_m [DEPTH];
  int           wcmd_q [$];
  logic [143:0] data_q [$];
  logic [127:0] exp_q [$];
  int           due_q [$];
  int           edges_m = 0;
  int           s_edges = 0;
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;
  bit           cmd_acc;
  bit           data_acc;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic int line_of(input logic [26:0] addr);
    return int'((addr >> 3) % DEPTH);
  endfunction

  function automatic logic [26:0] rand_addr();
    return {12'($urandom_range(0, 4095)), 12'($urandom_range(0, 15)), 3'($urandom_range(0, 7))};
  endfunction

  // One clock: check ready outputs, advance the model, then check registered outputs.
  task automatic cycle();
    bit           calib, rdy_e, wrdy_e, s_rdy_e;
    logic         ref_e, zq_e, rst_now;
    logic [143:0] beat;
    logic [127:0] line;
    int           idx;
    calib   = (edges_m >= CAL);
    rdy_e   = calib && (wcmd_q.size() == 0);
    wrdy_e  = calib && (data_q.size() < 4);
    s_rdy_e = (s_edges >= CAL_S) && (((s_edges - CAL_S) % 3) != 2);
    check("app_rdy", app_rdy, rdy_e);
    check("app_wdf_rdy", app_wdf_rdy, wrdy_e);
    check("stall_app_rdy", s_rdy, s_rdy_e);
    check("stall_wdf_rdy", s_wdf_rdy, s_edges >= CAL_S);
    cmd_acc  = 1'b0;
    data_acc = 1'b0;
    rst_now  = rst_in;
    ref_e    = rst_in & app_ref_req;
    zq_e     = rst_in & app_zq_req;
    if (!rst_in) begin
      edges_m = 0;
      s_edges = 0;
      wcmd_q.delete();
      data_q.delete();
      exp_q.delete();
      due_q.delete();
    end else begin
      edges_m++;
      s_edges++;
      if (app_en && rdy_e) begin
        cmd_acc = 1'b1;
        if (app_cmd == MIG_CMD_WRITE) wcmd_q.push_back(line_of(app_addr));
        else if (app_cmd == MIG_CMD_READ) begin
          exp_q.push_back(mem_m[line_of(app_addr)]);
          due_q.push_back(cyc + L);
        end
      end
      if (app_wdf_wren && wrdy_e) begin
        data_acc = 1'b1;
        data_q.push_back({app_wdf_mask, app_wdf_data});
      end
      while (wcmd_q.size() > 0 && data_q.size() > 0) begin
        idx  = wcmd_q.pop_front();
        beat = data_q.pop_front();
        line = mem_m[idx];
        for (int b = 0; b < 16; b++) if (!beat[128 + b]) line[b*8 +: 8] = beat[b*8 +: 8];
        mem_m[idx] = line;
      end
    end
    @(posedge clk_in);
    cyc++;
    #1;
    check("init_calib_complete", init_calib_complete, edges_m >= CAL);
    check("stall_calib", s_calib, s_edges >= CAL_S);
    check("app_ref_ack", app_ref_ack, ref_e);
    check("app_zq_ack", app_zq_ack, zq_e);
    check("app_sr_active", app_sr_active, 1'b0);
    check("stall_quiet", {s_valid, s_end, s_sr, s_ref_ack, s_zq_ack, s_rd_data}, '0);
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      check("rd_valid", app_rd_data_valid, 1'b1);
      check("rd_end", app_rd_data_end, 1'b1);
      check("rd_data", app_rd_data, exp_q.pop_front());
      void'(due_q.pop_front());
    end else begin
      check("rd_valid_idle", app_rd_data_valid, 1'b0);
      check("rd_end_idle", app_rd_data_end, 1'b0);
      if (!rst_now) check("rd_data_reset", app_rd_data, '0);
    end
  endtask

  // Driver tasks: hold each valid until the model says it transferred.
  task automatic step();
    cycle();
    if (cmd_acc) app_en = 1'b0;
    if (data_acc) app_wdf_wren = 1'b0;
  endtask

  task automatic run_until_done();
    for (int i = 0; i < 32 && (app_en || app_wdf_wren); i++) step();
    check("handshake_timeout", {app_en, app_wdf_wren}, 2'b00);
    app_en = 1'b0;
    app_wdf_wren = 1'b0;
  endtask

  task automatic write_line(input logic [26:0] addr, input logic [127:0] data, input logic [15:0] mask);
    app_en = 1'b1; app_cmd = MIG_CMD_WRITE; app_addr = addr;
    app_wdf_wren = 1'b1; app_wdf_data = data; app_wdf_mask = mask;
    run_until_done();
  endtask

  task automatic read_line(input logic [26:0] addr);
    app_en = 1'b1; app_cmd = MIG_CMD_READ; app_addr = addr;
    run_until_done();
  endtask

  task automatic idle(input int n);
    app_en = 1'b0; app_wdf_wren = 1'b0;
    repeat (n) cycle();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL global_timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

  initial begin
    for (int i = 0; i < DEPTH; i++) mem_m[i] = '0;
    rst_in = 1'b0; app_addr = '0; app_cmd = '0; app_en = 1'b0;
    app_wdf_data = '0; app_wdf_mask = '0; app_wdf_wren = 1'b0; app_wdf_end = 1'b1;
    app_sr_req = 1'b0; app_ref_req = 1'b0; app_zq_req = 1'b0;
    repeat (2) @(posedge clk_in);
    #1;
    repeat (3) cycle();

    // Calibration: commands and data offered throughout must be ignored; acks still work.
    rst_in = 1'b1;
    app_en = 1'b1; app_cmd = MIG_CMD_READ; app_addr = rand_addr();
    app_wdf_wren = 1'b1; app_wdf_data = {4{$urandom}};
    for (int i = 0; i < CAL; i++) begin
      app_ref_req = 1'($urandom_range(0, 1));
      app_zq_req  = 1'($urandom_range(0, 1));
      cycle();
    end
    app_en = 1'b0; app_wdf_wren = 1'b0; app_ref_req = 1'b0; app_zq_req = 1'b0;

    // Preload the working set of lines.
    for (int k = 0; k < 16; k++)
      write_line({12'($urandom_range(0, 4095)), 12'(k), 3'd0}, {4{$urandom}}, 16'h0000);

    // Full-line write to 0x10 and readback.
    write_line(27'h10, 128'hDEADBEEF_01234567_89ABCDEF_CAFEF00D, 16'h0000);
    read_line(27'h10);
    idle(L + 2);

    // Masked write: only the low four bytes change.
    write_line(27'h30, {128{1'b1}}, 16'h0000);
    write_line(27'h30, 128'h0, 16'hFFF0);
    read_line(27'h30);
    idle(L + 2);

    // Write command five cycles ahead of its data; a read waits behind it.
    app_en = 1'b1; app_cmd = MIG_CMD_WRITE; app_addr = 27'h50;
    step();
    app_en = 1'b1; app_cmd = MIG_CMD_READ; app_addr = 27'h50;
    repeat (5) step();
    app_wdf_wren = 1'b1; app_wdf_data = {4{$urandom}}; app_wdf_mask = 16'h0000;
    run_until_done();
    idle(L + 2);

    // Four beats ahead of their commands fill the FIFO; a fifth is refused.
    for (int k = 0; k < 4; k++) begin
      app_wdf_wren = 1'b1; app_wdf_data = {4{$urandom}}; app_wdf_mask = 16'($urandom);
      step();
    end
    app_wdf_wren = 1'b1; app_wdf_data = {4{$urandom}};
    step();
    app_wdf_wren = 1'b0;
    for (int k = 0; k < 4; k++) begin
      app_en = 1'b1; app_cmd = MIG_CMD_WRITE; app_addr = {12'd0, 12'(k + 4), 3'd0};
      run_until_done();
    end

    // Eight back-to-back reads.
    for (int k = 0; k < 8; k++) begin
      app_en = 1'b1; app_cmd = MIG_CMD_READ; app_addr = {12'd0, 12'(k + 2), 3'd0};
      step();
    end
    idle(L + 2);

    // Random traffic.
    for (int n = 0; n < 400; n++) begin
      int r;
      if (!app_en && $urandom_range(0, 2) != 0) begin
        r = int'($urandom_range(0, 9));
        app_en = 1'b1;
        app_cmd = (r < 4) ? MIG_CMD_WRITE : (r < 9) ? MIG_CMD_READ : 3'($urandom_range(2, 7));
        app_addr = rand_addr();
      end
      if (!app_wdf_wren && $urandom_range(0, 2) != 0) begin
        app_wdf_wren = 1'b1;
        app_wdf_data = {4{$urandom}};
        app_wdf_mask = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'h0000;
      end
      app_ref_req = ($urandom_range(0, 3) == 0);
      app_zq_req  = ($urandom_range(0, 3) == 0);
      step();
    end
    app_en = 1'b0; app_ref_req = 1'b0; app_zq_req = 1'b0;
    if (wcmd_q.size() > 0 && !app_wdf_wren) begin
      app_wdf_wren = 1'b1; app_wdf_data = {4{$urandom}}; app_wdf_mask = 16'h0000;
    end
    for (int i = 0; i < 8 && app_wdf_wren; i++) step();
    idle(L + 2);
    check("drain_random", exp_q.size(), 0);

    // Reset with three reads in flight: none may emerge, calibration restarts.
    for (int k = 0; k < 3; k++) begin
      app_en = 1'b1; app_cmd = MIG_CMD_READ; app_addr = rand_addr();
      step();
    end
    idle(2);
    rst_in = 1'b0;
    idle(2);
    rst_in = 1'b1;
    idle(CAL + 2);
    read_line(27'h10);
    read_line(27'h30);
    idle(L + 2);
    check("drain_final", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
